// File: rtl/frame_control.sv
// Frame sequencer for the FMCW chain: ADF config, capture into the FIFO, then FFT or drain, NUM_CHIRPS per frame.
// Optional per-state watchdog enabled by defining FRAME_CONTROL_TIMEOUT_EN.
module frame_control #(
   parameter int unsigned NUM_CHIRPS     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1048576,
   parameter int unsigned CHIRP_W        = (NUM_CHIRPS > 1) ? $clog2(NUM_CHIRPS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic               adf_done,
   input  logic               window_valid,
   input  logic               fifo_full,
   input  logic               fifo_empty,
   input  logic               fft_done,
   output logic               adf_en,
   output logic               fir_en,
   output logic               fifo_wren,
   output logic               fifo_rden,
   output logic               fft_en,
   output logic               busy,
   output logic               frame_done,
   output logic [CHIRP_W-1:0] chirp_idx,
   output logic               timeout_err
);

   localparam logic [1:0] MODE_RAW = 2'd0;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ADF_CFG = 3'd1,
      S_ACQ     = 3'd2,
      S_FFT     = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   if (NUM_CHIRPS < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("frame_control: NUM_CHIRPS must be >= 1 and TIMEOUT_CYCLES >= 2");
   end

   state_t             state;
   state_t             state_next;
   logic [1:0]         mode_q;
   logic               fft_dly;
   logic               mode_fft_c;
   logic               last_chirp_c;
   logic               chirp_end_c;
   logic               frame_end_c;
   logic               frame_start_c;
   logic               state_change_c;
   logic               abort_c;

   // mode 3 aliases FFT, so the MSB alone selects the FFT path
   assign mode_fft_c     = mode_q[1];
   assign last_chirp_c   = (chirp_idx == CHIRP_W'(NUM_CHIRPS - 1));
   assign frame_start_c  = (state == S_IDLE) && start;
   assign frame_end_c    = chirp_end_c && last_chirp_c;
   assign state_change_c = (state_next != state);

`ifdef FRAME_CONTROL_TIMEOUT_EN
   localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WD_W-1:0] wd_cnt;
   logic            wd_hit_c;

   assign wd_hit_c = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   // dwell counter, restarted on every state entry
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (state_change_c) begin
         wd_cnt <= '0;
      end else if (state != S_IDLE) begin
         wd_cnt <= wd_cnt + WD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_err <= 1'b0;
      end else if (frame_start_c) begin
         timeout_err <= 1'b0;
      end else if (abort_c) begin
         timeout_err <= 1'b1;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next-state decode; a real exit always wins over the watchdog
   always_comb begin
      state_next  = state;
      chirp_end_c = 1'b0;
      abort_c     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_ADF_CFG;
         end
         S_ADF_CFG: begin
            if (adf_done) state_next = S_ACQ;
         end
         S_ACQ: begin
            if (fifo_full) state_next = mode_fft_c ? S_FFT : S_DRAIN;
         end
         S_FFT: begin
            if (fft_done) chirp_end_c = 1'b1;
         end
         S_DRAIN: begin
            if (fifo_empty) chirp_end_c = 1'b1;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      if (chirp_end_c) begin
         if (last_chirp_c) begin
            state_next = start ? S_ADF_CFG : S_IDLE;
         end else begin
            state_next = S_ACQ;
         end
      end

`ifdef FRAME_CONTROL_TIMEOUT_EN
      if ((state != S_IDLE) && (state_next == state) && wd_hit_c) begin
         state_next = S_IDLE;
         abort_c    = 1'b1;
      end
`endif
   end

   // enable decode from state, latched mode and the FIFO handshake
   always_comb begin
      adf_en    = 1'b0;
      fir_en    = 1'b0;
      fifo_wren = 1'b0;
      fifo_rden = 1'b0;
      fft_en    = 1'b0;
      busy      = (state != S_IDLE);
      case (state)
         S_ADF_CFG: begin
            adf_en = 1'b1;
         end
         S_ACQ: begin
            adf_en    = 1'b1;
            fir_en    = (mode_q != MODE_RAW);
            fifo_wren = window_valid & ~fifo_full;
         end
         S_FFT: begin
            fifo_rden = 1'b1;
            fft_en    = fft_dly;
         end
         S_DRAIN: begin
            fifo_rden = ~fifo_empty;
         end
         default: begin
            busy = (state != S_IDLE);
         end
      endcase
   end

   // frame bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= MODE_RAW;
         chirp_idx  <= '0;
         frame_done <= 1'b0;
         fft_dly    <= 1'b0;
      end else begin
         if (frame_start_c) begin
            mode_q <= mode;
         end

         if (frame_start_c || abort_c || frame_end_c) begin
            chirp_idx <= '0;
         end else if (chirp_end_c) begin
            chirp_idx <= chirp_idx + CHIRP_W'(1);
         end

         frame_done <= frame_end_c && !abort_c;

         // one cycle of FIFO read latency before the FFT sees data
         if (state_change_c) begin
            fft_dly <= 1'b0;
         end else if (state == S_FFT) begin
            fft_dly <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_frame_control.sv
// Directed bench for frame_control: vector table plus hand-written reset, continuous and watchdog sequences.
module tb_frame_control;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] mode;
   logic       adf_done;
   logic       window_valid;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fft_done;
   logic       adf_en;
   logic       fir_en;
   logic       fifo_wren;
   logic       fifo_rden;
   logic       fft_en;
   logic       busy;
   logic       frame_done;
   logic [1:0] chirp_idx;
   logic       timeout_err;

   logic [7:0] flags;
   int         n_checks;
   int         n_fail;
   int         pulses;

   frame_control #(
      .NUM_CHIRPS     (4),
      .TIMEOUT_CYCLES (16),
      .CHIRP_W        (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mode         (mode),
      .adf_done     (adf_done),
      .window_valid (window_valid),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .fft_done     (fft_done),
      .adf_en       (adf_en),
      .fir_en       (fir_en),
      .fifo_wren    (fifo_wren),
      .fifo_rden    (fifo_rden),
      .fft_en       (fft_en),
      .busy         (busy),
      .frame_done   (frame_done),
      .chirp_idx    (chirp_idx),
      .timeout_err  (timeout_err)
   );

   // {adf_en, fir_en, fifo_wren, fifo_rden, fft_en, busy, frame_done, timeout_err}
   assign flags = {adf_en, fir_en, fifo_wren, fifo_rden, fft_en, busy, frame_done, timeout_err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1) pulses <= pulses + 1;
   end

   // in = {rst, start, mode[1:0], adf_done, window_valid, fifo_full, fifo_empty, fft_done}
   typedef struct {
      logic [8:0] in;
      logic [7:0] exp;
      logic [1:0] idx;
   } vec_t;

   vec_t vecs[39];

   task automatic apply(input logic [8:0] in);
      @(negedge clk);
      {rst, start, mode, adf_done, window_valid, fifo_full, fifo_empty, fft_done} = in;
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global time limit reached");
      $fatal(1);
   end

   initial begin
      int p0;
      n_checks = 0;
      n_fail   = 0;
      pulses   = 0;
      {rst, start, mode, adf_done, window_valid, fifo_full, fifo_empty, fft_done} = '0;

      // FIR frame, start dropped mid-frame; then FFT (mode 3) frame into continuous; reset; RAW
      vecs[0]  = '{9'b0_0_00_00000, 8'b0000_0000, 2'd0};
      vecs[1]  = '{9'b0_1_01_00000, 8'b0000_0000, 2'd0};
      vecs[2]  = '{9'b0_1_00_00000, 8'b1000_0100, 2'd0};
      vecs[3]  = '{9'b0_0_00_10000, 8'b1000_0100, 2'd0};
      vecs[4]  = '{9'b0_0_00_01000, 8'b1110_0100, 2'd0};
      vecs[5]  = '{9'b0_0_00_01100, 8'b1100_0100, 2'd0};
      vecs[6]  = '{9'b0_0_00_00000, 8'b0001_0100, 2'd0};
      vecs[7]  = '{9'b0_0_00_00010, 8'b0000_0100, 2'd0};
      vecs[8]  = '{9'b0_0_00_00100, 8'b1100_0100, 2'd1};
      vecs[9]  = '{9'b0_0_00_00010, 8'b0000_0100, 2'd1};
      vecs[10] = '{9'b0_0_00_00100, 8'b1100_0100, 2'd2};
      vecs[11] = '{9'b0_0_00_00010, 8'b0000_0100, 2'd2};
      vecs[12] = '{9'b0_0_00_00100, 8'b1100_0100, 2'd3};
      vecs[13] = '{9'b0_0_00_00010, 8'b0000_0100, 2'd3};
      vecs[14] = '{9'b0_0_00_00000, 8'b0000_0010, 2'd0};
      vecs[15] = '{9'b0_0_00_00000, 8'b0000_0000, 2'd0};
      vecs[16] = '{9'b0_1_11_00000, 8'b0000_0000, 2'd0};
      vecs[17] = '{9'b0_0_00_10000, 8'b1000_0100, 2'd0};
      vecs[18] = '{9'b0_0_00_00100, 8'b1100_0100, 2'd0};
      vecs[19] = '{9'b0_0_00_00000, 8'b0001_0100, 2'd0};
      vecs[20] = '{9'b0_0_00_00101, 8'b0001_1100, 2'd0};
      vecs[21] = '{9'b0_0_00_00100, 8'b1100_0100, 2'd1};
      vecs[22] = '{9'b0_0_00_00001, 8'b0001_0100, 2'd1};
      vecs[23] = '{9'b0_0_00_00100, 8'b1100_0100, 2'd2};
      vecs[24] = '{9'b0_0_00_00001, 8'b0001_0100, 2'd2};
      vecs[25] = '{9'b0_0_00_00100, 8'b1100_0100, 2'd3};
      vecs[26] = '{9'b0_0_00_00000, 8'b0001_0100, 2'd3};
      vecs[27] = '{9'b0_0_00_00000, 8'b0001_1100, 2'd3};
      vecs[28] = '{9'b0_1_00_00001, 8'b0001_1100, 2'd3};
      vecs[29] = '{9'b0_1_00_00000, 8'b1000_0110, 2'd0};
      vecs[30] = '{9'b0_0_00_00000, 8'b1000_0100, 2'd0};
      vecs[31] = '{9'b1_0_00_00000, 8'b1000_0100, 2'd0};
      vecs[32] = '{9'b0_1_00_00000, 8'b0000_0000, 2'd0};
      vecs[33] = '{9'b0_0_00_10000, 8'b1000_0100, 2'd0};
      vecs[34] = '{9'b0_0_00_01000, 8'b1010_0100, 2'd0};
      vecs[35] = '{9'b0_0_00_01100, 8'b1000_0100, 2'd0};
      vecs[36] = '{9'b0_0_00_00000, 8'b0001_0100, 2'd0};
      vecs[37] = '{9'b0_0_00_00010, 8'b0000_0100, 2'd0};
      vecs[38] = '{9'b0_0_00_00000, 8'b1000_0100, 2'd1};

      apply(9'b1_0_00_00000);
      apply(9'b1_0_00_00000);
      apply(9'b0_0_00_00000);
      check("reset flags", 32'(flags), 32'h0);
      check("reset chirp_idx", 32'(chirp_idx), 32'h0);

      for (int i = 0; i < 39; i++) begin
         apply(vecs[i].in);
         check($sformatf("vec%0d flags", i), 32'(flags), 32'(vecs[i].exp));
         check($sformatf("vec%0d chirp_idx", i), 32'(chirp_idx), 32'(vecs[i].idx));
      end

      // reset while in FFT on chirp 2
      apply(9'b1_0_00_00000);
      apply(9'b0_1_10_00000);
      apply(9'b0_0_00_10000);
      for (int k = 0; k < 2; k++) begin
         apply(9'b0_0_00_00100);
         apply(9'b0_0_00_00001);
      end
      apply(9'b0_0_00_00100);
      apply(9'b0_0_00_00000);
      check("fft idx2 flags", 32'(flags), 32'h14);
      check("fft idx2 chirp_idx", 32'(chirp_idx), 32'd2);
      apply(9'b1_0_00_00000);
      apply(9'b0_0_00_00000);
      check("post-reset flags", 32'(flags), 32'h0);
      check("post-reset chirp_idx", 32'(chirp_idx), 32'h0);

      // continuous: three frames with start held, mode changed mid-run
      apply(9'b0_1_01_00000);
      p0 = pulses;
      for (int f = 0; f < 3; f++) begin
         apply(9'b0_1_00_10000);
         if (f > 0) check($sformatf("cont frame%0d adf+done", f), 32'({adf_en, frame_done}), 32'h3);
         for (int c = 0; c < 4; c++) begin
            apply(9'b0_1_00_00100);
            check($sformatf("cont f%0d c%0d fir_en", f, c), 32'(fir_en), 32'h1);
            apply(9'b0_1_00_00010);
         end
      end
      apply(9'b0_1_00_00000);
      check("cont frame3 adf+done", 32'({adf_en, frame_done}), 32'h3);
      check("cont pulse count", 32'(pulses - p0), 32'd3);
      apply(9'b0_0_00_10000);
      for (int c = 0; c < 4; c++) begin
         apply(9'b0_0_00_00100);
         apply(9'b0_0_00_00010);
      end
      apply(9'b0_0_00_00000);
      check("cont stop idle", 32'({busy, frame_done}), 32'h1);

      // new mode takes effect only from the next IDLE start
      apply(9'b0_1_00_00000);
      apply(9'b0_0_11_10000);
      apply(9'b0_0_11_01000);
      check("raw latch flags", 32'(flags), 32'hA4);
      apply(9'b1_0_00_00000);

      // watchdog on withheld adf_done
      apply(9'b0_1_00_00000);
      for (int k = 1; k <= 16; k++) begin
         apply(9'b0_0_00_00000);
         check($sformatf("wd dwell %0d", k), 32'({adf_en, busy}), 32'h3);
      end
      apply(9'b0_0_00_00000);
`ifdef FRAME_CONTROL_TIMEOUT_EN
      check("wd expired flags", 32'(flags), 32'h01);
      check("wd expired chirp_idx", 32'(chirp_idx), 32'h0);
      apply(9'b0_0_00_00000);
      check("wd sticky", 32'(flags), 32'h01);
      apply(9'b0_1_00_00000);
      check("wd sticky at start", 32'(timeout_err), 32'h1);
      apply(9'b0_0_00_00000);
      check("wd cleared by start", 32'(flags), 32'h84);
`else
      check("wd disabled flags", 32'(flags), 32'h84);
      for (int k = 0; k < 8; k++) apply(9'b0_0_00_00000);
      check("wd disabled still waiting", 32'(flags), 32'h84);
`endif
      apply(9'b1_0_00_00000);
      apply(9'b0_0_00_00000);
      check("final idle", 32'(flags), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
